// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file write port, with stall hold.
// Define ROUND_ROBIN_EN for a toggling priority pointer; otherwise req1 wins contention.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Register,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Register,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
  input  logic              writeStall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_next;
  logic              can_accept;
  logic              both_valid;
  logic              same_reg;
  logic              contended;
  logic              pick1;
  logic              accept;
  logic              wr_accept;
  logic [ADDR_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_data;

`ifdef ROUND_ROBIN_EN
  logic prio_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_ptr <= 1'b0;
    else if (contended) prio_ptr <= ~prio_ptr;
  end

  assign pick1 = prio_ptr;
`else
  assign pick1 = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    can_accept = 1'b0;
    req0Ready  = 1'b0;
    req1Ready  = 1'b0;
    both_valid = req0Valid && req1Valid;
    same_reg   = (req0Register == req1Register);

    // A pending write that the register file refuses must not be overwritten.
    if (state == IDLE) can_accept = !reset && !(regWrite && writeStall);

    if (can_accept) begin
      if (both_valid && same_reg) begin
        req0Ready = 1'b1;
        req1Ready = 1'b1;
      end else if (both_valid) begin
        req0Ready = !pick1;
        req1Ready = pick1;
      end else begin
        req0Ready = req0Valid;
        req1Ready = req1Valid;
      end
    end

    contended = can_accept && both_valid && !same_reg;
    accept    = req0Ready || req1Ready;
    // On a coalesced write req1 is the younger value, so it takes precedence.
    acc_reg   = req1Ready ? req1Register : req0Register;
    acc_data  = req1Ready ? req1Data : req0Data;
    wr_accept = accept && (acc_reg != '0);

    case (state)
      IDLE:    if (writeStall && (regWrite || wr_accept)) state_next = HOLD;
      HOLD:    if (!writeStall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite <= wr_accept || (regWrite && writeStall);
      if (wr_accept) begin
        writeRegister <= acc_reg;
        writeData     <= acc_data;
      end
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: scoreboard of expected register-file writes
// plus immediate checks of readies, busy and output registers.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Register, req1Register;
  logic [63:0] req0Data, req1Data;
  logic        req0Ready, req1Ready;
  logic        writeStall;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;
  logic        busy;

  typedef struct packed {
    logic [4:0]  rg;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

`ifdef ROUND_ROBIN_EN
  logic rr_ptr = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0Valid    (req0Valid),
    .req0Register (req0Register),
    .req0Data     (req0Data),
    .req0Ready    (req0Ready),
    .req1Valid    (req1Valid),
    .req1Register (req1Register),
    .req1Data     (req1Data),
    .req1Ready    (req1Ready),
    .writeStall   (writeStall),
    .regWrite     (regWrite),
    .writeRegister(writeRegister),
    .writeData    (writeData),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit point: a write completes when presented while the register file is not stalled.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (regWrite && !writeStall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_write: observed reg %0d data %0h, expected no write",
               writeRegister, writeData);
      end else begin
        e = exp_q.pop_front();
        check("sb_reg", 64'(writeRegister), 64'(e.rg));
        check("sb_data", writeData, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic contend(input logic [63:0] d0, input logic [63:0] d1);
    logic first1;
`ifdef ROUND_ROBIN_EN
    first1 = rr_ptr;
    rr_ptr = ~rr_ptr;
`else
    first1 = 1'b1;
`endif
    req0Valid = 1'b1; req0Register = 5'd4; req0Data = d0;
    req1Valid = 1'b1; req1Register = 5'd5; req1Data = d1;
    if (first1) begin
      exp_q.push_back('{5'd5, d1});
      exp_q.push_back('{5'd4, d0});
    end else begin
      exp_q.push_back('{5'd4, d0});
      exp_q.push_back('{5'd5, d1});
    end
    #1;
    check("cont_rdy0", 64'(req0Ready), 64'(!first1));
    check("cont_rdy1", 64'(req1Ready), 64'(first1));
    tick();
    check("cont_first_we", 64'(regWrite), 64'(1));
    check("cont_first_reg", 64'(writeRegister), first1 ? 64'd5 : 64'd4);
    if (first1) req1Valid = 1'b0;
    else        req0Valid = 1'b0;
    #1;
    check("cont_loser_rdy", 64'(first1 ? req0Ready : req1Ready), 64'(1));
    tick();
    check("cont_no_bubble", 64'(regWrite), 64'(1));
    check("cont_second_reg", 64'(writeRegister), first1 ? 64'd4 : 64'd5);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    tick();
    check("cont_idle_we", 64'(regWrite), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    req0Valid = 1'b0; req0Register = '0; req0Data = '0;
    req1Valid = 1'b0; req1Register = '0; req1Data = '0;
    writeStall = 1'b0;
    #2;
    check("rst_we", 64'(regWrite), 64'(0));
    check("rst_reg", 64'(writeRegister), 64'(0));
    check("rst_data", writeData, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single uncontended write, latency 1.
    req0Valid = 1'b1; req0Register = 5'd3; req0Data = 64'hAA;
    exp_q.push_back('{5'd3, 64'hAA});
    #1;
    check("single_rdy0", 64'(req0Ready), 64'(1));
    check("single_rdy1", 64'(req1Ready), 64'(0));
    tick();
    check("single_we", 64'(regWrite), 64'(1));
    check("single_reg", 64'(writeRegister), 64'd3);
    check("single_data", writeData, 64'hAA);
    req0Valid = 1'b0;
    tick();
    check("single_we_drop", 64'(regWrite), 64'(0));
    check("single_reg_keep", 64'(writeRegister), 64'd3);

    // Contention twice: exercises pointer toggle when round robin is enabled.
    contend(64'h11, 64'h22);
    contend(64'h33, 64'h44);

    // Same index from both: coalesced, req1 data wins.
    req0Valid = 1'b1; req0Register = 5'd7; req0Data = 64'h1;
    req1Valid = 1'b1; req1Register = 5'd7; req1Data = 64'h2;
    exp_q.push_back('{5'd7, 64'h2});
    #1;
    check("coal_rdy0", 64'(req0Ready), 64'(1));
    check("coal_rdy1", 64'(req1Ready), 64'(1));
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    check("coal_we", 64'(regWrite), 64'(1));
    check("coal_data", writeData, 64'h2);
    tick();
    check("coal_single", 64'(regWrite), 64'(0));

    // Write to x0 is accepted and dropped.
    req1Valid = 1'b1; req1Register = 5'd0; req1Data = 64'hFF;
    #1;
    check("x0_rdy1", 64'(req1Ready), 64'(1));
    tick();
    req1Valid = 1'b0;
    check("x0_we", 64'(regWrite), 64'(0));
    check("x0_busy", 64'(busy), 64'(0));

    // Accept under stall, hold three cycles, then complete.
    writeStall = 1'b1;
    req0Valid = 1'b1; req0Register = 5'd9; req0Data = 64'h99;
    exp_q.push_back('{5'd9, 64'h99});
    #1;
    check("stall_rdy0", 64'(req0Ready), 64'(1));
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1Register = 5'd12; req1Data = 64'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_busy", 64'(busy), 64'(1));
      check("hold_we", 64'(regWrite), 64'(1));
      check("hold_reg", 64'(writeRegister), 64'd9);
      check("hold_rdy1", 64'(req1Ready), 64'(0));
      if (i < 2) tick();
    end
    writeStall = 1'b0;
    #1;
    check("hold_exit_rdy1", 64'(req1Ready), 64'(0));
    tick();
    check("hold_exit_busy", 64'(busy), 64'(0));
    check("hold_exit_we", 64'(regWrite), 64'(0));
    exp_q.push_back('{5'd12, 64'h5});
    #1;
    check("post_hold_rdy1", 64'(req1Ready), 64'(1));
    tick();
    req1Valid = 1'b0;
    check("post_hold_reg", 64'(writeRegister), 64'd12);
    tick();

    // Reset asserted mid-HOLD clears outputs without a clock edge.
    writeStall = 1'b1;
    req0Valid = 1'b1; req0Register = 5'd20; req0Data = 64'h77;
    tick();
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("async_rst_we", 64'(regWrite), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_reg", 64'(writeRegister), 64'(0));
    check("async_rst_data", writeData, 64'(0));
    check("async_rst_rdy0", 64'(req0Ready), 64'(0));
    writeStall = 1'b0;
    req0Valid = 1'b0;
    tick();
    reset = 1'b0;
`ifdef ROUND_ROBIN_EN
    rr_ptr = 1'b0;
`endif
    req0Valid = 1'b1; req0Register = 5'd21; req0Data = 64'h66;
    exp_q.push_back('{5'd21, 64'h66});
    #1;
    check("after_rst_rdy0", 64'(req0Ready), 64'(1));
    tick();
    req0Valid = 1'b0;
    check("after_rst_we", 64'(regWrite), 64'(1));
    check("after_rst_reg", 64'(writeRegister), 64'd21);
    tick();
    tick();

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
